aud_recorder: RTL and testbench

I2S capture engine for the WM8731 ADC path, the receiving counterpart of the DAC playback path. It oversamples the codec's BCLK/ADCLRCK/ADCDAT in the 12 MHz system domain and deserialises 16-bit samples. It writes each sample to SRAM through a single-cycle write strobe with an auto-incrementing address. Sits inside `Top` beside the I2C initialiser and the player, driven by debounced key pulses.

---
 rtl/aud_pkg.sv | 14 +
 rtl/aud_edge_sync.sv | 36 +++
 rtl/aud_recorder.sv | 165 ++++++++++++++++
 tb/tb_aud_recorder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// aud_pkg: shared capture FSM states and default widths for the audio recorder
package aud_pkg;
  localparam int AUD_ADDR_W    = 20;
  localparam int AUD_SAMPLE_W  = 16;
  localparam int AUD_BIT_CNT_W = $clog2(AUD_SAMPLE_W) + 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_SKIP,
    ST_SHIFT,
    ST_STORE,
    ST_PAUSED
  } rec_state_e;
endpackage

// File: rtl/aud_edge_sync.sv
// aud_edge_sync: 2-flop synchroniser with a delayed copy and registered rise/fall strobes
module aud_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] sync_q, sync_d;
  logic dly_q, dly_d, rise_q, rise_d, fall_q, fall_d;
  // shift the pin through the synchroniser and flag edges of the settled level
  always_comb begin
    sync_d = {sync_q[0], i_pin};
    dly_d  = sync_q[1];
    rise_d = sync_q[1] & ~dly_q;
    fall_d = ~sync_q[1] & dly_q;
  end
  // synchroniser, delayed copy and strobe registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign o_sync = sync_q[1];
  assign o_rise = rise_q;
  assign o_fall = fall_q;
endmodule

// File: rtl/aud_recorder.sv
// aud_recorder: WM8731 I2S ADC capture into SRAM words; define AUD_RECORDER_STEREO_EN to also capture the right channel
module aud_recorder
  import aud_pkg::*;
#(
  parameter int ADDR_W   = AUD_ADDR_W,
  parameter int SAMPLE_W = AUD_SAMPLE_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_AUD_BCLK,
  input  logic                i_AUD_ADCLRCK,
  input  logic                i_AUD_ADCDAT,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_wr,
  output logic [ADDR_W-1:0]   o_rec_len,
  output logic                o_busy,
  output logic                o_full
);
`ifdef AUD_RECORDER_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  localparam logic [AUD_BIT_CNT_W-1:0] LAST_BIT = AUD_BIT_CNT_W'(SAMPLE_W - 1);
  logic bclk_rise, lr_sync, dat_sync;
  logic bclk_lvl_unused, bclk_fall_unused, lr_rise_unused, lr_fall_unused, dat_rise_unused, dat_fall_unused;
  rec_state_e state_q, state_d;
  logic [AUD_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d, data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rec_len_q, rec_len_d;
  logic wr_q, wr_d, busy_q, busy_d, full_q, full_d, pause_q, pause_d;
  logic stop_q, stop_d, ch_q, ch_d, lr_prev_q, lr_prev_d;
  logic lr_fell, lr_rose, last, hold_pair;

  aud_edge_sync u_bclk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_AUD_BCLK),
    .o_sync (bclk_lvl_unused),
    .o_rise (bclk_rise),
    .o_fall (bclk_fall_unused)
  );
  aud_edge_sync u_lrck (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_AUD_ADCLRCK),
    .o_sync (lr_sync),
    .o_rise (lr_rise_unused),
    .o_fall (lr_fall_unused)
  );
  aud_edge_sync u_dat (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_AUD_ADCDAT),
    .o_sync (dat_sync),
    .o_rise (dat_rise_unused),
    .o_fall (dat_fall_unused)
  );

  // capture FSM: frame detection, bit shifting, write strobe and address bookkeeping
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    addr_d    = addr_q;
    rec_len_d = rec_len_q;
    full_d    = full_q;
    ch_d      = ch_q;
    wr_d      = 1'b0;
    lr_prev_d = bclk_rise ? lr_sync : lr_prev_q;
    lr_fell   = bclk_rise & lr_prev_q & ~lr_sync;
    lr_rose   = bclk_rise & ~lr_prev_q & lr_sync;
    last      = &addr_q;
    hold_pair = STEREO & (ch_q | (state_q == ST_STORE));
    pause_d   = pause_q | (i_pause & (state_q != ST_IDLE) & (state_q != ST_PAUSED));
    stop_d    = stop_q | (i_stop & hold_pair);
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d   = ST_WAIT_FRAME;
        addr_d    = '0;
        rec_len_d = '0;
        full_d    = 1'b0;
        ch_d      = 1'b0;
      end
      ST_WAIT_FRAME: if (ch_q ? lr_rose : lr_fell) state_d = ST_SKIP;
      ST_SKIP: if (bclk_rise) begin
        state_d   = ST_SHIFT;
        bit_cnt_d = '0;
      end
      ST_SHIFT: if (bclk_rise) begin
        shreg_d   = {shreg_q[SAMPLE_W-2:0], dat_sync};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_STORE;
          wr_d    = 1'b1;
          data_d  = shreg_d;
        end
      end
      ST_STORE: begin
        addr_d    = last ? addr_q : addr_q + 1'b1;
        rec_len_d = (&rec_len_q) ? rec_len_q : rec_len_q + 1'b1;
        full_d    = full_q | last;
        ch_d      = STEREO & ~ch_q;
        state_d   = ch_d ? ST_WAIT_FRAME : (stop_d | last) ? ST_IDLE : pause_d ? ST_PAUSED : ST_WAIT_FRAME;
        pause_d   = ch_d & pause_d;
        stop_d    = ch_d & stop_d;
      end
      ST_PAUSED: if (i_start && !i_pause) state_d = ST_WAIT_FRAME;
      default: state_d = ST_IDLE;
    endcase
    if (i_stop && !hold_pair) begin
      state_d = ST_IDLE;
      wr_d    = 1'b0;
      pause_d = 1'b0;
      stop_d  = 1'b0;
      ch_d    = 1'b0;
    end
    busy_d = state_d != ST_IDLE;
  end

  // all recorder state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      rec_len_q <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      pause_q   <= 1'b0;
      stop_q    <= 1'b0;
      ch_q      <= 1'b0;
      lr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      rec_len_q <= rec_len_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      pause_q   <= pause_d;
      stop_q    <= stop_d;
      ch_q      <= ch_d;
      lr_prev_q <= lr_prev_d;
    end
  end

  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_wr      = wr_q;
  assign o_rec_len = rec_len_q;
  assign o_busy    = busy_q;
  assign o_full    = full_q;
endmodule

// File: tb/tb_aud_recorder.sv
// tb_aud_recorder: directed I2S frames against the recorder with hand-computed write expectations
module tb_aud_recorder;
  localparam int AW = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic bclk = 1'b0, lrck = 1'b1, dat = 1'b0;
  logic [AW-1:0] addr, rec_len;
  logic [15:0] data;
  logic wr, busy, full;
  logic [AW-1:0] wa[$];
  logic [15:0] wd[$];
  int n_chk = 0, n_err = 0, slot_no = 0;

  aud_recorder #(.ADDR_W(AW), .SAMPLE_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_pause       (pause),
    .i_stop        (stop),
    .i_AUD_BCLK    (bclk),
    .i_AUD_ADCLRCK (lrck),
    .i_AUD_ADCDAT  (dat),
    .o_addr        (addr),
    .o_data        (data),
    .o_wr          (wr),
    .o_rec_len     (rec_len),
    .o_busy        (busy),
    .o_full        (full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr) begin
    wa.push_back(addr);
    wd.push_back(data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_len"}, 32'(rec_len), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [AW-1:0] ea, input logic [15:0] ed);
    check({tag, "_waddr"}, idx < wa.size() ? 32'(wa[idx]) : 32'hFFFF_FFFF, 32'(ea));
    check({tag, "_wdata"}, idx < wd.size() ? 32'(wd[idx]) : 32'hFFFF_FFFF, 32'(ed));
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    @(negedge clk);
    start = s;
    pause = p;
    stop  = t;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic send_slot(input logic l, input logic d);
    bclk = 1'b0;
    lrck = l;
    dat  = d;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // 20 BCLKs per half: detect rise, skip rise, then 16 bits MSB first
  task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw);
    for (int i = 0; i < 40; i++) begin
      int j;
      logic [15:0] w;
      j = i % 20;
      w = (i < 20) ? lw : rw;
      slot_no = i;
      send_slot(i >= 20, (j >= 2 && j <= 17) ? w[17-j] : 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");
    repeat (4) send_slot(1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("start_busy", 32'(busy), 32'd1);
`ifdef AUD_RECORDER_STEREO_EN
    send_frame(16'h0001, 16'h8000);
    check("st_nwr", 32'(wa.size()), 32'd2);
    check_wr("st_left", 0, 4'd0, 16'h0001);
    check_wr("st_right", 1, 4'd1, 16'h8000);
    check("st_len", 32'(rec_len), 32'd2);
`else
    send_frame(16'hA5C3, 16'hFFFF);
    send_frame(16'h1234, 16'hFFFF);
    check("mono_nwr", 32'(wa.size()), 32'd2);
    check_wr("mono0", 0, 4'd0, 16'hA5C3);
    check_wr("mono1", 1, 4'd1, 16'h1234);
    check("mono_len", 32'(rec_len), 32'd2);
    check("mono_addr", 32'(addr), 32'd2);
    fork
      send_frame(16'hBEEF, 16'hFFFF);
      begin
        wait (slot_no == 9);
        pulse(1'b0, 1'b0, 1'b1);
        check("stop_busy", 32'(busy), 32'd0);
      end
    join
    check("stop_nwr", 32'(wa.size()), 32'd2);
    check("stop_addr", 32'(addr), 32'd2);
    check("stop_len", 32'(rec_len), 32'd2);
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'h0F0F, 16'hFFFF);
    check_wr("restart", 2, 4'd0, 16'h0F0F);
    check("restart_len", 32'(rec_len), 32'd1);
    fork
      send_frame(16'h5A5A, 16'hFFFF);
      begin
        wait (slot_no == 5);
        pulse(1'b0, 1'b1, 1'b0);
      end
    join
    check_wr("pause", 3, 4'd1, 16'h5A5A);
    check("paused_busy", 32'(busy), 32'd1);
    repeat (5) send_frame(16'h1111, 16'hFFFF);
    check("paused_nwr", 32'(wa.size()), 32'd4);
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'h2222, 16'hFFFF);
    check_wr("resume", 4, 4'd2, 16'h2222);
    pulse(1'b0, 1'b1, 1'b0);
    send_frame(16'h3333, 16'hFFFF);
    check_wr("pause2", 5, 4'd3, 16'h3333);
    pulse(1'b1, 1'b0, 1'b1);
    check("stopstart_busy", 32'(busy), 32'd0);
    send_frame(16'h4444, 16'hFFFF);
    check("stopstart_nwr", 32'(wa.size()), 32'd6);
    pulse(1'b1, 1'b0, 1'b0);
    fork
      send_frame(16'h7777, 16'hFFFF);
      begin
        wait (slot_no == 10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
      end
    join
    check("midrst_nwr", 32'(wa.size()), 32'd6);
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) send_frame(16'h0100 + 16'(k), 16'hFFFF);
    check("full_nwr", 32'(wa.size()), 32'd22);
    check_wr("full_first", 6, 4'd0, 16'h0100);
    check_wr("full_last", 21, 4'd15, 16'h010F);
    check("full_flag", 32'(full), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_addr", 32'(addr), 32'd15);
    check("full_len", 32'(rec_len), 32'd15);
    send_frame(16'hAAAA, 16'hFFFF);
    check("full_ignore_nwr", 32'(wa.size()), 32'd22);
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
